// File: rtl/rggen_indirect_access_initiator.sv
// Indirect register access initiator: turns one host command into an index write
// plus a data read/write on the rggen register bus, caching the last good index.
module rggen_indirect_access_initiator #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned INDEX_WIDTH    = 8,
  parameter int unsigned INDEX_ADDRESS  = 0,
  parameter int unsigned DATA_ADDRESS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [INDEX_WIDTH-1:0]   i_cmd_index,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH-1:0]     i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH-1:0]     o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0]     INDEX_STROBE = BUS_WIDTH'({INDEX_WIDTH{1'b1}});
  localparam logic [ADDRESS_WIDTH-1:0] INDEX_ADDR   = ADDRESS_WIDTH'(INDEX_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] DATA_ADDR    = ADDRESS_WIDTH'(DATA_ADDRESS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INDEX = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     cmd_ready_q;
  logic                     write_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BUS_WIDTH-1:0]     strobe_q;
  logic                     cache_valid_q;
  logic [INDEX_WIDTH-1:0]   cache_index_q;
  logic [CNT_WIDTH-1:0]     count_q;
  logic                     reg_valid_q;
  logic [1:0]               reg_access_q;
  logic [ADDRESS_WIDTH-1:0] reg_addr_q;
  logic [BUS_WIDTH-1:0]     reg_wdata_q;
  logic [BUS_WIDTH-1:0]     reg_strobe_q;
  logic                     rsp_valid_q;
  logic [1:0]               rsp_status_q;
  logic [BUS_WIDTH-1:0]     rsp_rdata_q;

  logic cache_hit;
  logic timeout_hit;
  logic index_ok;

  assign cache_hit   = cache_valid_q && (cache_index_q == i_cmd_index);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TIMEOUT_LAST);
  assign index_ok    = (state_q == INDEX) && i_register_ready && !i_register_status[1];

  // Ready wins over timeout: the timeout path is only taken when ready is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      index_q       <= '0;
      wdata_q       <= '0;
      strobe_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_index_q <= '0;
      count_q       <= '0;
      reg_valid_q   <= 1'b0;
      reg_access_q  <= 2'b00;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_strobe_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= 2'b00;
      rsp_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cmd_valid && cmd_ready_q) begin
            write_q     <= i_cmd_write;
            index_q     <= i_cmd_index;
            wdata_q     <= i_cmd_write_data;
            strobe_q    <= i_cmd_strobe;
            cmd_ready_q <= 1'b0;
            count_q     <= '0;
            reg_valid_q <= 1'b1;
            if (cache_hit) begin
              state_q      <= DATA;
              reg_access_q <= {1'b0, i_cmd_write};
              reg_addr_q   <= DATA_ADDR;
              reg_wdata_q  <= i_cmd_write ? i_cmd_write_data : '0;
              reg_strobe_q <= i_cmd_write ? i_cmd_strobe : '1;
            end else begin
              state_q      <= INDEX;
              reg_access_q <= 2'b01;
              reg_addr_q   <= INDEX_ADDR;
              reg_wdata_q  <= BUS_WIDTH'(i_cmd_index);
              reg_strobe_q <= INDEX_STROBE;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        INDEX, DATA: begin
          if (index_ok) begin
            state_q       <= DATA;
            cache_valid_q <= 1'b1;
            cache_index_q <= index_q;
            count_q       <= '0;
            reg_access_q  <= {1'b0, write_q};
            reg_addr_q    <= DATA_ADDR;
            reg_wdata_q   <= write_q ? wdata_q : '0;
            reg_strobe_q  <= write_q ? strobe_q : '1;
          end else if (i_register_ready || timeout_hit) begin
            state_q      <= RESP;
            reg_valid_q  <= 1'b0;
            reg_access_q <= 2'b00;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            reg_strobe_q <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= i_register_ready ? i_register_status : 2'b11;
            rsp_rdata_q  <= (i_register_ready && (state_q == DATA) && !write_q &&
                             !i_register_status[1]) ? i_register_read_data : '0;
            // Index errors and any timeout leave the slave's index unknown.
            if (!i_register_ready || (state_q == INDEX)) begin
              cache_valid_q <= 1'b0;
            end
          end else begin
            count_q <= count_q + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_rdata_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready           = cmd_ready_q;
  assign o_rsp_valid           = rsp_valid_q;
  assign o_rsp_status          = rsp_status_q;
  assign o_rsp_read_data       = rsp_rdata_q;
  assign o_register_valid      = reg_valid_q;
  assign o_register_access     = reg_access_q;
  assign o_register_address    = reg_addr_q;
  assign o_register_write_data = reg_wdata_q;
  assign o_register_strobe     = reg_strobe_q;

endmodule

// File: tb/tb_rggen_indirect_access_initiator.sv
// Directed bench for rggen_indirect_access_initiator with a 4-cycle bus timeout.
module tb_rggen_indirect_access_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_index;
  logic [31:0] cmd_wdata, cmd_strobe;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic        reg_valid;
  logic [1:0]  reg_access;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_strobe;
  logic        reg_ready;
  logic [1:0]  reg_status;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rggen_indirect_access_initiator #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .INDEX_WIDTH(8),
    .INDEX_ADDRESS(0), .DATA_ADDRESS(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_index(cmd_index), .i_cmd_write_data(cmd_wdata), .i_cmd_strobe(cmd_strobe),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_status(rsp_status),
    .o_rsp_read_data(rsp_rdata),
    .o_register_valid(reg_valid), .o_register_access(reg_access),
    .o_register_address(reg_addr), .o_register_write_data(reg_wdata),
    .o_register_strobe(reg_strobe), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_chk(input string tag, input logic [1:0] acc, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] st);
    chk({tag, "_valid"}, 32'(reg_valid), 32'd1);
    chk({tag, "_access"}, 32'(reg_access), 32'(acc));
    chk({tag, "_addr"}, 32'(reg_addr), 32'(addr));
    chk({tag, "_wdata"}, reg_wdata, wd);
    chk({tag, "_strobe"}, reg_strobe, st);
  endtask

  task automatic rsp_chk(input string tag, input logic [1:0] st, input logic [31:0] rd);
    chk({tag, "_bus_idle"}, 32'(reg_valid), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_status"}, 32'(rsp_status), 32'(st));
    chk({tag, "_rdata"}, rsp_rdata, rd);
  endtask

  task automatic send(input logic wr, input logic [7:0] idx, input logic [31:0] wd,
                      input logic [31:0] st);
    cmd_valid = 1'b1; cmd_write = wr; cmd_index = idx; cmd_wdata = wd; cmd_strobe = st;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    reg_ready = 1'b0; reg_status = 2'b00; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_wdata = '0;
    cmd_strobe = '0; rsp_ready = 1'b0; reg_ready = 1'b0; reg_status = 2'b00; reg_rdata = '0;
    tick(); tick();
    chk("rst_reg_valid", 32'(reg_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_wdata", reg_wdata, 32'd0);

    // Read index 5 with an empty cache: index write then data read.
    send(1'b0, 8'd5, 32'h0, 32'h0);
    bus_chk("t1_index", 2'b01, 8'd0, 32'h5, 32'hFF);
    chk("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    reg_ready = 1'b1; reg_rdata = 32'hDEADBEEF;
    tick();
    bus_chk("t1_data", 2'b00, 8'd4, 32'h0, 32'hFFFF_FFFF);
    tick();
    rsp_chk("t1_rsp", 2'b00, 32'hDEADBEEF);
    consume("t1");

    // Write index 5 again: cache hit, no index phase.
    send(1'b1, 8'd5, 32'h1234, 32'hFFFF);
    bus_chk("t2_data", 2'b01, 8'd4, 32'h1234, 32'hFFFF);
    reg_ready = 1'b1;
    tick();
    rsp_chk("t2_rsp", 2'b00, 32'h0);
    consume("t2");

    // SLVERR on the index phase skips data and invalidates the cache.
    send(1'b0, 8'd9, 32'h0, 32'h0);
    bus_chk("t3_index", 2'b01, 8'd0, 32'h9, 32'hFF);
    reg_ready = 1'b1; reg_status = 2'b10;
    tick();
    rsp_chk("t3_rsp", 2'b10, 32'h0);
    consume("t3");
    send(1'b0, 8'd5, 32'h0, 32'h0);
    bus_chk("t3_reindex", 2'b01, 8'd0, 32'h5, 32'hFF);
    reg_ready = 1'b1; reg_rdata = 32'hCAFE0001;
    tick();
    bus_chk("t3_data", 2'b00, 8'd4, 32'h0, 32'hFFFF_FFFF);
    tick();
    rsp_chk("t3_rsp2", 2'b00, 32'hCAFE0001);
    consume("t3b");

    // Ready never arrives: valid held for exactly 4 cycles, then timeout.
    send(1'b0, 8'd7, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_wait_valid", 32'(reg_valid), 32'd1);
      tick();
    end
    chk("t4_wait_valid_last", 32'(reg_valid), 32'd1);
    tick();
    rsp_chk("t4_rsp", 2'b11, 32'h0);
    chk("t4_addr_cleared", 32'(reg_addr), 32'd0);
    consume("t4");
    send(1'b1, 8'd5, 32'h0000AA55, 32'h0000000F);
    bus_chk("t4_reindex", 2'b01, 8'd0, 32'h5, 32'hFF);
    reg_ready = 1'b1;
    tick();
    bus_chk("t5_data", 2'b01, 8'd4, 32'h0000AA55, 32'h0000000F);
    tick();
    reg_ready = 1'b0;

    // Response held for 10 cycles with i_rsp_ready low.
    for (int i = 0; i < 10; i++) begin
      rsp_chk("t5_hold", 2'b00, 32'h0);
      chk("t5_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    consume("t5");

    // Reset during the data phase drops the bus at once and flushes the cache.
    send(1'b0, 8'd5, 32'h0, 32'h0);
    bus_chk("t6_data", 2'b00, 8'd4, 32'h0, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(reg_valid), 32'd0);
    chk("t6_rst_addr", 32'(reg_addr), 32'd0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    send(1'b0, 8'd5, 32'h0, 32'h0);
    bus_chk("t6_reindex", 2'b01, 8'd0, 32'h5, 32'hFF);
    reg_ready = 1'b1; reg_rdata = 32'h600DF00D;
    tick();
    bus_chk("t6_data2", 2'b00, 8'd4, 32'h0, 32'hFFFF_FFFF);
    tick();
    rsp_chk("t6_rsp", 2'b00, 32'h600DF00D);
    consume("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
